hazard_seq_ctrl: RTL
====================

HAZARD_SEQ_CTRL -- requirements
Module: hazard_seq_ctrl

Interface
REQ-001 Parameter: MAX_WAIT, default 16, maximum consecutive data-memory wait cycles before timeout (range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 Rs1D, Rs2D  input  5 each  source registers in Decode.
REQ-005 Rs1E, Rs2E, RdE  input  5 each  source and destination registers in Execute.
REQ-006 RdM, RdW  input  5 each  destination registers in Memory and Writeback.
REQ-007 RegWriteM, RegWriteW  input  1 each  register-write enables in Memory and Writeback.
REQ-008 ResultSrcE  input  2  Execute result select; value 2'b01 means load.
REQ-009 PCSrcE  input  1  branch or jump taken in Execute.
REQ-010 MemReqM, MemReadyM  input  1 each  data-memory access pending in Memory, and memory ready.
REQ-011 StallF, StallD, StallE, StallM  output  1 each  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-012 FlushD, FlushE, FlushW  output  1 each  bubble into IF/ID, ID/EX and MEM/WB.
REQ-013 ForwardAE, ForwardBE  output  2 each  ALU operand select: 00 register file, 01 Writeback, 10 Memory.
REQ-014 MemBusy  output  1  the FSM is in MEM_WAIT; MemErr  output  1  sticky timeout flag.

Function
REQ-015 Forwarding SHALL be combinational: ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW and RdW!=0 and RdW==Rs1E; else 00. ForwardBE SHALL use Rs2E with the same rule.
REQ-016 lwStall = (ResultSrcE==01) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D); it SHALL assert StallF, StallD and FlushE for exactly that cycle.
REQ-017 PCSrcE=1 SHALL assert FlushD and FlushE in the same cycle.
REQ-018 FSM states SHALL be RUN, MEM_WAIT and ERROR.
REQ-019 memStall = MemReqM and not MemReadyM, evaluated in RUN or MEM_WAIT (Mealy: stalls assert in the first miss cycle).
REQ-020 RUN SHALL move to MEM_WAIT when memStall; MEM_WAIT SHALL return to RUN on the first cycle MemReadyM=1.
REQ-021 A wait counter (8 bits) SHALL clear in RUN and increment each MEM_WAIT cycle that memStall=1.
REQ-022 In MEM_WAIT, if the counter equals MAX_WAIT-1 and MemReadyM=0, the next state SHALL be ERROR and MemErr SHALL set.
REQ-023 While memStall=1: StallF, StallD, StallE, StallM and FlushW SHALL be 1, and FlushD, FlushE and the lwStall effects SHALL be 0 (memory stall has priority; the held PCSrcE or lwStall reapplies after release).
REQ-024 ERROR: StallF, StallD, StallE and StallM SHALL be 1, FlushW=1 and all flushes except FlushW SHALL be 0; ERROR is left only by reset.
REQ-025 PCSrcE and lwStall together SHALL yield StallF=StallD=FlushD=FlushE=1.
REQ-026 MemBusy SHALL be registered, equal to (state==MEM_WAIT).

Reset
REQ-027 With rst=1 at a rising clk, the FSM SHALL go to RUN and the counter, MemBusy and MemErr SHALL clear to 0.
REQ-028 While rst=1, all stall and flush outputs SHALL be forced to 0.
REQ-029 Reset during MEM_WAIT or ERROR SHALL abandon the access, with no residual stall in the cycle after reset deasserts.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN: when defined, outputs StallCnt[31:0] and FlushCnt[31:0] SHALL exist.
REQ-031 StallCnt SHALL count cycles with StallF=1 and FlushCnt SHALL count cycles with FlushE=1; both SHALL clear on reset and wrap from 0xFFFFFFFF to 0.
REQ-032 When HAZARD_PERF_CNT_EN is undefined, these ports and counters SHALL be absent, with behaviour otherwise identical.

Verification
REQ-033 RdM=5, RegWriteM=1, Rs1E=5; RdW=5, RegWriteW=1 -> ForwardAE=10 (Memory wins). Rs1E=0 -> ForwardAE=00.
REQ-034 ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle. RdE=0 with the same inputs -> no stall.
REQ-035 MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> stalls and FlushW high for 3 cycles, MemBusy high for cycles 2-4, back in RUN.
REQ-036 MAX_WAIT=4, MemReadyM held 0 -> ERROR after 5 stall cycles, MemErr=1 and stalls persist; rst=1 for 1 cycle -> all outputs 0.
REQ-037 PCSrcE=1 during a memory stall -> FlushD=FlushE=0 until release; on the release cycle FlushD=FlushE=1.
REQ-038 With HAZARD_PERF_CNT_EN defined, run the REQ-035 sequence -> StallCnt=3 and FlushCnt=0.

Source files
------------

// File: rtl/hazard_seq_ctrl.sv
// hazard_seq_ctrl: pipeline hazard unit for a 5-stage core with a
// wait-stated data memory.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   Rs1D, Rs2D                Decode source registers
//   Rs1E, Rs2E, RdE           Execute source/destination registers
//   RdM, RdW                  Memory / Writeback destination registers
//   RegWriteM, RegWriteW      register-write enables in Memory / Writeback
//   ResultSrcE                Execute result select (2'b01 = load)
//   PCSrcE                    branch/jump taken in Execute
//   MemReqM, MemReadyM        data-memory request pending / memory ready
//   StallF/D/E/M              hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/W                bubble into IF/ID, ID/EX, MEM/WB
//   ForwardAE, ForwardBE      ALU operand select (00 RF, 01 WB, 10 MEM)
//   MemBusy                   registered, high while in MEM_WAIT
//   MemErr                    sticky memory-timeout flag
//   StallCnt, FlushCnt        (HAZARD_PERF_CNT_EN only) cycles with StallF
//                             and FlushE high, wrapping 32-bit counters
//
// Optional feature macro: HAZARD_PERF_CNT_EN
module hazard_seq_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemBusy,
  output logic       MemErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       lw_stall;
  logic       mem_stall;

  // Forwarding: the Memory stage holds the younger result, so it wins.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = (state != ERROR) && MemReqM && !MemReadyM;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_stall) state_nxt = MEM_WAIT;
      MEM_WAIT: begin
        if (!mem_stall)                  state_nxt = RUN;
        else if (wait_cnt == WAIT_LAST)  state_nxt = ERROR;
      end
      ERROR:    state_nxt = ERROR;
      default:  state_nxt = RUN;
    endcase
  end

  // Memory stall and ERROR freeze the whole pipe and suppress the
  // branch/load flushes; those inputs are held and reapply on release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      // all stall/flush outputs forced low during reset
    end else if ((state == ERROR) || mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = PCSrcE | lw_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      MemBusy  <= 1'b0;
      MemErr   <= 1'b0;
    end else begin
      state   <= state_nxt;
      MemBusy <= (state_nxt == MEM_WAIT);
      if (state_nxt == ERROR) MemErr <= 1'b1;
      if (state == RUN)                    wait_cnt <= '0;
      else if ((state == MEM_WAIT) && mem_stall) wait_cnt <= wait_cnt + 8'd1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF) StallCnt <= StallCnt + 32'd1;
      if (FlushE) FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule
